int_sched_ctrl: RTL and testbench
=================================

Name: int_sched_ctrl

Overview:
- Memory-mapped interrupt scheduler between the peripheral interrupt sources (timer0, timer1, external interrupt line) and the CP0 HWInt inputs of the pipelined MIPS core.
- Latches source edges into pending bits and applies a mask.
- Selects the highest-priority pending source and presents it to CP0 as a one-hot HWInt request.
- Sequences claim/service/EOI so that only one interrupt is in service at a time. Sits behind the system bridge at 0x7F20–0x7F2F.

Parameters:
- NSRC, 6: number of interrupt sources (1..6); bit i maps to HWInt[i].
- BASE_ADDR, 32'h0000_7F20: base of the 16-byte register window.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- irq_src  input  NSRC  raw source lines from peripherals, synchronous to clk
- sel  input  1  bridge decode hit for BASE_ADDR..BASE_ADDR+0xF
- addr  input  32  byte address from the M stage
- wdata  input  32  write data
- byteen  input  4  byte enables; a write occurs when sel && |byteen
- rd_en  input  1  read strobe (load in M stage), only meaningful with sel
- rdata  output  32  read data, combinational
- hwint  output  6  one-hot request to CP0 HWInt[5:0]; bits >= NSRC tied 0
- busy  output  1  high while the FSM is in SERV

Behaviour:
- Reset (reset_n low, asynchronous): pend=0, mask=all ones, src_q=0, state=IDLE, cur_id=0, act_id=0, hwint=0, busy=0. rdata is 0 whenever sel is low.
- Register map, offset = addr[3:2]; addr[1:0] and byteen pattern are ignored:
  - +0x0 EOI: write-only, reads 0.
  - +0x4 MASK: RW, NSRC bits.
  - +0x8 PEND: read returns pend; write is W1C with wdata[NSRC-1:0].
  - +0xC CLAIM: read-with-side-effect.
- Edge detect: src_q <= irq_src every cycle; rise = irq_src & ~src_q. pend[i] is set at the edge where rise[i] is high.
- Same-cycle rise and clear (W1C or claim) on bit i: set wins; pend[i] ends 1.
- eligible = pend & mask. Priority: lowest index wins (timer0 > timer1 > ext ...).
- FSM states:
  - IDLE: if |eligible, go to REQ next edge and latch cur_id = priority index of eligible.
  - REQ: hwint = 1<<cur_id. Each cycle re-evaluate: if a higher-priority bit becomes eligible, cur_id updates (preemption before claim). If eligible==0 (masked or W1C), return to IDLE with hwint=0 next cycle.
  - CLAIM read in REQ: rdata = cur_id+1. At the edge, pend[cur_id] clears, act_id <= cur_id, and the FSM goes to SERV.
  - CLAIM read in IDLE or SERV: rdata = 0, no side effect.
  - SERV: hwint=0 and busy=1; pend keeps accumulating; MASK and PEND stay accessible.
  - Any write to EOI in SERV: return to IDLE next edge, and a pending eligible source re-enters REQ the following cycle.
  - EOI write in IDLE or REQ: ignored.
- Latency: source high at edge k gives pend=1 after k, state REQ and hwint valid after k+1. CLAIM at edge m gives hwint=0 from m onward.
- Simultaneous CLAIM read and write in the same cycle cannot happen; if it does, the write is processed and the read side effect is suppressed.
- The MASK write takes effect the edge after it is written; eligible uses the registered mask.
- reset_n asserted mid-SERV aborts service; all state returns to reset values.

Optional Feature:
- INT_LEVEL_TRIG_EN. When defined, pend[i] is set every cycle irq_src[i] is high (level-triggered); W1C and claim clear only take effect once the source is low, so a still-asserted source re-pends immediately after EOI.
- When undefined, behaviour is edge-triggered as above, and a held-high source pends exactly once per rising edge.

Test Plan:
- Reset with irq_src=0 -> hwint=0, busy=0; PEND read=0x0, MASK read=0x3F.
- Pulse irq_src[2] one cycle at t0 -> PEND=0x4 after t0, hwint=6'b000100 one cycle later; CLAIM read -> rdata=3, hwint=0, busy=1; EOI write to 0x7F20 -> IDLE, PEND=0.
- Raise irq_src[4] and irq_src[1] in the same cycle -> hwint=6'b000010; CLAIM -> 2; EOI -> hwint=6'b010000 two cycles later; CLAIM -> 5.
- In REQ for id 3, write MASK=0x37 -> hwint drops to 0, state IDLE, PEND still 0x8; write MASK=0x3F -> hwint=6'b001000 again.
- In REQ, W1C PEND with 0x1 in the same cycle irq_src[0] rises -> pend[0] stays 1 (set wins).
- Assert reset_n=0 while busy=1 with PEND=0x20 -> immediate busy=0, hwint=0, PEND=0, MASK=0x3F; with INT_LEVEL_TRIG_EN and irq_src[0] held high, W1C 0x1 leaves PEND=0x1.

Source files
------------

// File: rtl/int_sched_ctrl.sv
// Memory-mapped interrupt scheduler: edge-latched pending bits, mask, fixed priority, claim/EOI sequencing.
// Optional macro INT_LEVEL_TRIG_EN switches the sources from edge- to level-triggered pending.
module int_sched_ctrl #(
  parameter int          NSRC      = 6,
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F20
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [NSRC-1:0] irq_src,
  input  logic            sel,
  input  logic [31:0]     addr,
  input  logic [31:0]     wdata,
  input  logic [3:0]      byteen,
  input  logic            rd_en,
  output logic [31:0]     rdata,
  output logic [5:0]      hwint,
  output logic            busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_SERV
  } state_t;

  typedef logic [NSRC-1:0] src_vec_t;

  localparam logic [1:0] OFF_EOI   = 2'd0;
  localparam logic [1:0] OFF_MASK  = 2'd1;
  localparam logic [1:0] OFF_PEND  = 2'd2;
  localparam logic [1:0] OFF_CLAIM = 2'd3;

  state_t   state, state_n;
  logic [2:0] cur_id, cur_id_n;
  logic [2:0] act_id, act_id_n;
  logic [2:0] prio_id;
  src_vec_t pend, pend_n;
  src_vec_t mask;
  src_vec_t src_q;
  src_vec_t rise;
  src_vec_t eligible;
  src_vec_t clr_vec;
  src_vec_t clr_eff;
  src_vec_t set_vec;

  logic       hit;
  logic [1:0] off;
  logic       wr;
  logic       rd;
  logic       eoi_wr;
  logic       mask_wr;
  logic       pend_wr;
  logic       claim_rd;
  logic       claim_fire;

  assign hit      = sel && (addr[31:4] == BASE_ADDR[31:4]);
  assign off      = addr[3:2];
  // A write in the same cycle as a read wins and suppresses the read side effect.
  assign wr       = hit && (|byteen);
  assign rd       = hit && rd_en && !wr;
  assign eoi_wr   = wr && (off == OFF_EOI);
  assign mask_wr  = wr && (off == OFF_MASK);
  assign pend_wr  = wr && (off == OFF_PEND);
  assign claim_rd = rd && (off == OFF_CLAIM);

  assign rise     = irq_src & ~src_q;
  assign eligible = pend & mask;

  // Lowest index has the highest priority.
  always_comb begin
    prio_id = 3'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (eligible[i]) prio_id = 3'(i);
    end
  end

  always_comb begin
    state_n    = state;
    cur_id_n   = cur_id;
    act_id_n   = act_id;
    claim_fire = 1'b0;
    case (state)
      S_IDLE: begin
        if (|eligible) begin
          state_n  = S_REQ;
          cur_id_n = prio_id;
        end
      end
      S_REQ: begin
        if (claim_rd) begin
          claim_fire = 1'b1;
          act_id_n   = cur_id;
          state_n    = S_SERV;
        end else if (|eligible) begin
          cur_id_n = prio_id;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_SERV: begin
        if (eoi_wr) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    clr_vec = '0;
    if (pend_wr)    clr_vec = clr_vec | wdata[NSRC-1:0];
    if (claim_fire) clr_vec = clr_vec | (src_vec_t'(1) << cur_id);
  end

  // A new set always beats a clear landing on the same bit.
`ifdef INT_LEVEL_TRIG_EN
  assign set_vec = irq_src;
  assign clr_eff = clr_vec & ~irq_src;
`else
  assign set_vec = rise;
  assign clr_eff = clr_vec;
`endif

  assign pend_n = (pend & ~clr_eff) | set_vec;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      cur_id <= 3'd0;
      act_id <= 3'd0;
    end else begin
      state  <= state_n;
      cur_id <= cur_id_n;
      act_id <= act_id_n;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend  <= '0;
      mask  <= '1;
      src_q <= '0;
    end else begin
      pend  <= pend_n;
      src_q <= irq_src;
      if (mask_wr) mask <= wdata[NSRC-1:0];
    end
  end

  always_comb begin
    rdata = 32'd0;
    if (hit) begin
      case (off)
        OFF_MASK:  rdata[NSRC-1:0] = mask;
        OFF_PEND:  rdata[NSRC-1:0] = pend;
        OFF_CLAIM: if (state == S_REQ && !wr) rdata = 32'(cur_id) + 32'd1;
        default:   rdata = 32'd0;
      endcase
    end
  end

  assign hwint = (state == S_REQ) ? (6'd1 << cur_id) : 6'd0;
  assign busy  = (state == S_SERV);

  logic unused_ok;
  assign unused_ok = ^{addr[1:0], wdata[31:NSRC], act_id, rise};

endmodule

// File: tb/tb_int_sched_ctrl.sv
// Scoreboard bench for int_sched_ctrl: expected values queued per stimulus, popped when outputs are sampled.
module tb_int_sched_ctrl;

  localparam logic [31:0] BASE      = 32'h0000_7F20;
  localparam logic [31:0] OFF_EOI   = 32'h0;
  localparam logic [31:0] OFF_MASK  = 32'h4;
  localparam logic [31:0] OFF_PEND  = 32'h8;
  localparam logic [31:0] OFF_CLAIM = 32'hC;

  logic        clk;
  logic        reset_n;
  logic [5:0]  irq_src;
  logic        sel;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  byteen;
  logic        rd_en;
  logic [31:0] rdata;
  logic [5:0]  hwint;
  logic        busy;

  int checks;
  int errors;

  typedef struct {
    string       tag;
    logic [31:0] value;
  } exp_t;

  exp_t sb[$];

  int_sched_ctrl #(.NSRC(6), .BASE_ADDR(BASE)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .irq_src (irq_src),
    .sel     (sel),
    .addr    (addr),
    .wdata   (wdata),
    .byteen  (byteen),
    .rd_en   (rd_en),
    .rdata   (rdata),
    .hwint   (hwint),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic pushExpected(input string tag, input logic [31:0] value);
    exp_t e;
    e.tag   = tag;
    e.value = value;
    sb.push_back(e);
  endtask

  task automatic observe(input logic [31:0] actual);
    exp_t e;
    if (sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL sb_underflow: got 0x%0h expected queued entry", actual);
    end else begin
      e = sb.pop_front();
      checkOutput(e.tag, actual, e.value);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [31:0] a, input logic [31:0] w,
                               input logic [3:0] be, input logic r);
    sel    = s;
    addr   = a;
    wdata  = w;
    byteen = be;
    rd_en  = r;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkPins(input string tag, input logic [5:0] exp_hwint, input logic exp_busy);
    pushExpected({tag, "_hwint"}, {26'd0, exp_hwint});
    pushExpected({tag, "_busy"}, {31'd0, exp_busy});
    #1;
    observe({26'd0, hwint});
    observe({31'd0, busy});
  endtask

  task automatic peek(input logic [31:0] off, input string tag, input logic [31:0] exp_val);
    applyStimulus(1'b1, BASE + off, 32'd0, 4'h0, 1'b1);
    pushExpected(tag, exp_val);
    #1;
    observe(rdata);
    applyStimulus(1'b0, BASE + off, 32'd0, 4'h0, 1'b0);
  endtask

  task automatic busRead(input logic [31:0] off, input string tag, input logic [31:0] exp_val);
    applyStimulus(1'b1, BASE + off, 32'd0, 4'h0, 1'b1);
    pushExpected(tag, exp_val);
    #1;
    observe(rdata);
    step();
    applyStimulus(1'b0, BASE + off, 32'd0, 4'h0, 1'b0);
  endtask

  task automatic busWrite(input logic [31:0] off, input logic [31:0] data);
    applyStimulus(1'b1, BASE + off, data, 4'hF, 1'b0);
    step();
    applyStimulus(1'b0, BASE + off, 32'd0, 4'h0, 1'b0);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    irq_src = 6'd0;
    applyStimulus(1'b0, 32'd0, 32'd0, 4'h0, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Reset state and register defaults.
    checkPins("reset", 6'h00, 1'b0);
    applyStimulus(1'b0, BASE + OFF_MASK, 32'd0, 4'h0, 1'b1);
    pushExpected("rdata_nosel", 32'd0);
    #1;
    observe(rdata);
    applyStimulus(1'b0, BASE, 32'd0, 4'h0, 1'b0);
    busRead(OFF_PEND, "rst_pend", 32'h00);
    busRead(OFF_MASK, "rst_mask", 32'h3F);

    // Single pulse on source 2 through claim and EOI.
    irq_src = 6'h04;
    step();
    irq_src = 6'h00;
    checkPins("t1_idle", 6'h00, 1'b0);
    busRead(OFF_PEND, "t1_pend", 32'h04);
    checkPins("t1_req", 6'h04, 1'b0);
    busRead(OFF_CLAIM, "t1_claim", 32'd3);
    checkPins("t1_serv", 6'h00, 1'b1);
    busRead(OFF_CLAIM, "t1_claim_serv", 32'd0);
    busRead(OFF_PEND, "t1_pend_serv", 32'h00);
    busWrite(OFF_EOI, 32'd0);
    checkPins("t1_eoi", 6'h00, 1'b0);
    busRead(OFF_CLAIM, "t1_claim_idle", 32'd0);

    // Two simultaneous sources: lower index first, the other re-requests after EOI.
    irq_src = 6'h12;
    step();
    irq_src = 6'h00;
    step();
    checkPins("t2_req1", 6'h02, 1'b0);
    busRead(OFF_CLAIM, "t2_claim1", 32'd2);
    busWrite(OFF_EOI, 32'd0);
    checkPins("t2_idle", 6'h00, 1'b0);
    step();
    checkPins("t2_req4", 6'h10, 1'b0);
    busRead(OFF_CLAIM, "t2_claim4", 32'd5);
    busWrite(OFF_EOI, 32'd0);

    // Masking while requesting, EOI ignored outside service.
    irq_src = 6'h08;
    step();
    irq_src = 6'h00;
    step();
    checkPins("t3_req", 6'h08, 1'b0);
    busWrite(OFF_EOI, 32'd0);
    checkPins("t3_eoi_ign", 6'h08, 1'b0);
    busWrite(OFF_MASK, 32'h37);
    checkPins("t3_mask_lag", 6'h08, 1'b0);
    step();
    checkPins("t3_masked", 6'h00, 1'b0);
    busRead(OFF_PEND, "t3_pend", 32'h08);
    busRead(OFF_MASK, "t3_mask", 32'h37);
    busWrite(OFF_MASK, 32'h3F);
    step();
    checkPins("t3_unmask", 6'h08, 1'b0);

    // W1C colliding with a rising edge, then preemption by the higher-priority bit.
    irq_src = 6'h01;
    busWrite(OFF_PEND, 32'h01);
    irq_src = 6'h00;
    checkPins("t4_pre", 6'h08, 1'b0);
    busRead(OFF_PEND, "t4_set_wins", 32'h09);
    checkPins("t4_preempt", 6'h01, 1'b0);
    busRead(OFF_CLAIM, "t4_claim", 32'd1);
    busWrite(OFF_EOI, 32'd0);
    step();
    busRead(OFF_CLAIM, "t4_claim3", 32'd4);

    // Pending accumulates in service; reset aborts everything.
    irq_src = 6'h20;
    step();
    irq_src = 6'h00;
    checkPins("t5_serv", 6'h00, 1'b1);
    busRead(OFF_PEND, "t5_pend", 32'h20);
    busWrite(OFF_MASK, 32'h15);
    busRead(OFF_MASK, "t5_mask", 32'h15);
    checkPins("t5_still_serv", 6'h00, 1'b1);
    reset_n = 1'b0;
    checkPins("t5_rst", 6'h00, 1'b0);
    peek(OFF_PEND, "t5_rst_pend", 32'h00);
    peek(OFF_MASK, "t5_rst_mask", 32'h3F);
    step();
    reset_n = 1'b1;
    step();

`ifdef INT_LEVEL_TRIG_EN
    // Held source re-pends through a W1C until it drops.
    irq_src = 6'h01;
    step();
    busWrite(OFF_PEND, 32'h01);
    busRead(OFF_PEND, "l_w1c_held", 32'h01);
    checkPins("l_req", 6'h01, 1'b0);
    irq_src = 6'h00;
    busWrite(OFF_PEND, 32'h01);
    step();
    checkPins("l_clear", 6'h00, 1'b0);
    busRead(OFF_PEND, "l_pend", 32'h00);
`else
    // Held source pends only once per rising edge.
    irq_src = 6'h01;
    step();
    step();
    checkPins("e_req", 6'h01, 1'b0);
    busRead(OFF_CLAIM, "e_claim", 32'd1);
    busWrite(OFF_EOI, 32'd0);
    step();
    checkPins("e_once", 6'h00, 1'b0);
    busRead(OFF_PEND, "e_pend", 32'h00);
    irq_src = 6'h00;
`endif

    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL sb_leftover: got %0d entries expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
